// File: rtl/tl_ad_buffer.sv
// ---------------------------------------------------------------------------
// tl_ad_buffer
//   TileLink-UH A/D channel buffer. It sits between the FIFO-fixer stage and a
//   crossbar slave port. The A channel (requests, in -> out) and the D channel
//   (responses, out -> in) each pass through their own circular queue. The
//   queues break every combinational ready/valid path. Beats are never
//   reordered, merged or dropped.
//
// Parameters
//   A_DEPTH   A-channel queue entries (1..8)
//   D_DEPTH   D-channel queue entries (1..8)
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   auto_in_a_*                  upstream A channel (ready out, rest in)
//   auto_out_a_*                 downstream A channel (ready in, rest out)
//   auto_out_d_*                 downstream D channel (ready out, rest in)
//   auto_in_d_*                  upstream D channel (ready in, rest out)
//   idle                         both queues empty
// ---------------------------------------------------------------------------

// Generic registered circular queue: no flow-through, no full-queue bypass.
module tl_ad_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic              empty
);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRIES = 1 << PTR_W;

  logic [DATA_W-1:0] storage [ENTRIES];
  logic [PTR_W-1:0]  enq_ptr;
  logic [PTR_W-1:0]  deq_ptr;
  logic [3:0]        count;
  logic              enq_fire;
  logic              deq_fire;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Ready looks only at the registered count: a dequeue in the same cycle
  // does not open a slot for a beat presented to a full queue.
  assign enq_ready = (count != 4'(DEPTH)) && !reset;
  assign deq_valid = (count != 4'd0);
  assign deq_bits  = storage[deq_ptr];
  assign empty     = (count == 4'd0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= 4'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        storage[i] <= '0;
      end
    end else begin
      if (enq_fire) begin
        storage[enq_ptr] <= enq_bits;
        enq_ptr          <= ptr_inc(enq_ptr);
      end
      if (deq_fire) begin
        deq_ptr <= ptr_inc(deq_ptr);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

module tl_ad_buffer #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  // upstream A
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [2:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  // upstream D
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_source,
  output logic [63:0] auto_in_d_bits_data,
  // downstream A
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [2:0]  auto_out_a_bits_source,
  output logic [30:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  // downstream D
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [2:0]  auto_out_d_bits_source,
  input  logic [63:0] auto_out_d_bits_data,
  output logic        idle
);
  localparam int A_W = 3 + 3 + 3 + 3 + 31 + 8 + 64 + 1;
  localparam int D_W = 3 + 3 + 3 + 64;

  logic [A_W-1:0] a_enq_bits;
  logic [A_W-1:0] a_deq_bits;
  logic [D_W-1:0] d_enq_bits;
  logic [D_W-1:0] d_deq_bits;
  logic           a_empty;
  logic           d_empty;

  assign a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param,
                       auto_in_a_bits_size, auto_in_a_bits_source,
                       auto_in_a_bits_address, auto_in_a_bits_mask,
                       auto_in_a_bits_data, auto_in_a_bits_corrupt};

  assign {auto_out_a_bits_opcode, auto_out_a_bits_param,
          auto_out_a_bits_size, auto_out_a_bits_source,
          auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_bits;

  assign d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_size,
                       auto_out_d_bits_source, auto_out_d_bits_data};

  assign {auto_in_d_bits_opcode, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_data} = d_deq_bits;

  tl_ad_queue #(.DEPTH(A_DEPTH), .DATA_W(A_W)) a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in_a_valid),
    .enq_ready (auto_in_a_ready),
    .enq_bits  (a_enq_bits),
    .deq_valid (auto_out_a_valid),
    .deq_ready (auto_out_a_ready),
    .deq_bits  (a_deq_bits),
    .empty     (a_empty)
  );

  tl_ad_queue #(.DEPTH(D_DEPTH), .DATA_W(D_W)) d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out_d_valid),
    .enq_ready (auto_out_d_ready),
    .enq_bits  (d_enq_bits),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_bits  (d_deq_bits),
    .empty     (d_empty)
  );

  // Derived from registered counts only; no input reaches idle.
  assign idle = a_empty && d_empty;
endmodule

// File: tb/tb_tl_ad_buffer.sv
module tb_tl_ad_buffer;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [2:0]  source;
    logic [30:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT with A_DEPTH = 2 ----------------
  a_beat_t     in_a;
  logic        in_a_valid, in_a_ready;
  logic        out_a_valid, out_a_ready;
  logic [2:0]  oa_opcode, oa_param, oa_size, oa_source;
  logic [30:0] oa_address;
  logic [7:0]  oa_mask;
  logic [63:0] oa_data;
  logic        oa_corrupt;
  logic        in_d_ready, in_d_valid;
  logic [2:0]  id_opcode, id_size, id_source;
  logic [63:0] id_data;
  logic        out_d_ready, out_d_valid;
  logic [2:0]  od_opcode, od_size, od_source;
  logic [63:0] od_data;
  logic        idle;

  tl_ad_buffer #(.A_DEPTH(2), .D_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(in_a.opcode), .auto_in_a_bits_param(in_a.param),
    .auto_in_a_bits_size(in_a.size), .auto_in_a_bits_source(in_a.source),
    .auto_in_a_bits_address(in_a.address), .auto_in_a_bits_mask(in_a.mask),
    .auto_in_a_bits_data(in_a.data), .auto_in_a_bits_corrupt(in_a.corrupt),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_size(id_size),
    .auto_in_d_bits_source(id_source), .auto_in_d_bits_data(id_data),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_size(od_size),
    .auto_out_d_bits_source(od_source), .auto_out_d_bits_data(od_data),
    .idle(idle)
  );

  // ---------------- DUT with A_DEPTH = 3 ----------------
  a_beat_t     s3_in_a;
  logic        s3_in_a_valid, s3_in_a_ready;
  logic        s3_out_a_valid, s3_out_a_ready;
  logic [2:0]  s3_oa_opcode, s3_oa_param, s3_oa_size, s3_oa_source;
  logic [30:0] s3_oa_address;
  logic [7:0]  s3_oa_mask;
  logic [63:0] s3_oa_data;
  logic        s3_oa_corrupt;
  logic        s3_in_d_ready, s3_in_d_valid;
  logic [2:0]  s3_id_opcode, s3_id_size, s3_id_source;
  logic [63:0] s3_id_data;
  logic        s3_out_d_ready, s3_out_d_valid;
  logic [2:0]  s3_od_opcode, s3_od_size, s3_od_source;
  logic [63:0] s3_od_data;
  logic        s3_idle;

  tl_ad_buffer #(.A_DEPTH(3), .D_DEPTH(2)) dut3 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(s3_in_a_ready), .auto_in_a_valid(s3_in_a_valid),
    .auto_in_a_bits_opcode(s3_in_a.opcode), .auto_in_a_bits_param(s3_in_a.param),
    .auto_in_a_bits_size(s3_in_a.size), .auto_in_a_bits_source(s3_in_a.source),
    .auto_in_a_bits_address(s3_in_a.address), .auto_in_a_bits_mask(s3_in_a.mask),
    .auto_in_a_bits_data(s3_in_a.data), .auto_in_a_bits_corrupt(s3_in_a.corrupt),
    .auto_in_d_ready(s3_in_d_ready), .auto_in_d_valid(s3_in_d_valid),
    .auto_in_d_bits_opcode(s3_id_opcode), .auto_in_d_bits_size(s3_id_size),
    .auto_in_d_bits_source(s3_id_source), .auto_in_d_bits_data(s3_id_data),
    .auto_out_a_ready(s3_out_a_ready), .auto_out_a_valid(s3_out_a_valid),
    .auto_out_a_bits_opcode(s3_oa_opcode), .auto_out_a_bits_param(s3_oa_param),
    .auto_out_a_bits_size(s3_oa_size), .auto_out_a_bits_source(s3_oa_source),
    .auto_out_a_bits_address(s3_oa_address), .auto_out_a_bits_mask(s3_oa_mask),
    .auto_out_a_bits_data(s3_oa_data), .auto_out_a_bits_corrupt(s3_oa_corrupt),
    .auto_out_d_ready(s3_out_d_ready), .auto_out_d_valid(s3_out_d_valid),
    .auto_out_d_bits_opcode(s3_od_opcode), .auto_out_d_bits_size(s3_od_size),
    .auto_out_d_bits_source(s3_od_source), .auto_out_d_bits_data(s3_od_data),
    .idle(s3_idle)
  );

  function automatic a_beat_t out_a_beat();
    a_beat_t r;
    r.opcode = oa_opcode;   r.param = oa_param;  r.size = oa_size;
    r.source = oa_source;   r.address = oa_address;
    r.mask = oa_mask;       r.data = oa_data;    r.corrupt = oa_corrupt;
    return r;
  endfunction

  function automatic a_beat_t s3_out_a_beat();
    a_beat_t r;
    r.opcode = s3_oa_opcode;  r.param = s3_oa_param;  r.size = s3_oa_size;
    r.source = s3_oa_source;  r.address = s3_oa_address;
    r.mask = s3_oa_mask;      r.data = s3_oa_data;    r.corrupt = s3_oa_corrupt;
    return r;
  endfunction

  function automatic a_beat_t rand_beat();
    a_beat_t r;
    r.opcode  = 3'($urandom);
    r.param   = 3'($urandom);
    r.size    = 3'($urandom);
    r.source  = 3'($urandom);
    r.address = 31'($urandom);
    r.mask    = 8'($urandom);
    r.data    = {$urandom, $urandom};
    r.corrupt = 1'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_a = '0; in_a_valid = 1'b0; out_a_ready = 1'b0; in_d_ready = 1'b0;
    out_d_valid = 1'b0; od_opcode = '0; od_size = '0; od_source = '0; od_data = '0;
    s3_in_a = '0; s3_in_a_valid = 1'b0; s3_out_a_ready = 1'b0; s3_in_d_ready = 1'b0;
    s3_out_d_valid = 1'b0; s3_od_opcode = '0; s3_od_size = '0; s3_od_source = '0;
    s3_od_data = '0;
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (in_a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_a_ready: got %b want 0", in_a_ready); end
    n_tests++; if (out_d_ready !== 1'b0) begin n_fail++; $display("FAIL rst_out_d_ready: got %b want 0", out_d_ready); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
    reset = 1'b0;
    #1;
    n_tests++; if (in_a_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_a_ready: got %b want 1", in_a_ready); end
    n_tests++; if (out_d_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_out_d_ready: got %b want 1", out_d_ready); end
    n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_a_valid: got %b want 0", out_a_valid); end
    n_tests++; if (in_d_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_in_d_valid: got %b want 0", in_d_valid); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: got %b want 1", idle); end
    n_tests++; if (out_a_beat() !== a_beat_t'(0)) begin n_fail++; $display("FAIL post_rst_a_bits: got %h want 0", out_a_beat()); end
    n_tests++; if ({id_opcode, id_size, id_source, id_data} !== 73'd0) begin n_fail++; $display("FAIL post_rst_d_bits: got %h want 0", {id_opcode, id_size, id_source, id_data}); end
    n_tests++; if (s3_idle !== 1'b1) begin n_fail++; $display("FAIL post_rst_s3_idle: got %b want 1", s3_idle); end
  endtask

  task automatic test_single_a();
    a_beat_t b;
    b = rand_beat();
    b.opcode = 3'd4; b.source = 3'd5; b.address = 31'h4000_0010; b.mask = 8'hFF;
    @(posedge clock); #1;
    in_a = b; in_a_valid = 1'b1; out_a_ready = 1'b1;
    n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_flowthrough: got %b want 0", out_a_valid); end
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    n_tests++; if (out_a_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", out_a_valid); end
    n_tests++; if (out_a_beat() !== b) begin n_fail++; $display("FAIL single_out_bits: got %h want %h", out_a_beat(), b); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", idle); end
    @(posedge clock); #1;
    n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", out_a_valid); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_backpressure();
    a_beat_t b [3];
    int sent = 0;
    int rcv = 0;
    for (int i = 0; i < 3; i++) b[i] = rand_beat();
    for (int cyc = 0; cyc < 40 && rcv < 3; cyc++) begin
      @(posedge clock); #1;
      out_a_ready = (cyc >= 5);
      in_a_valid = (sent < 3);
      if (sent < 3) in_a = b[sent];
      if (cyc >= 2 && cyc <= 5) begin
        n_tests++; if (in_a_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready cyc%0d: got %b want 0", cyc, in_a_ready); end
      end
      if (in_a_valid && in_a_ready) sent++;
      if (out_a_valid && out_a_ready) begin
        n_tests++; if (out_a_beat() !== b[rcv]) begin n_fail++; $display("FAIL bp_order beat%0d: got %h want %h", rcv, out_a_beat(), b[rcv]); end
        rcv++;
      end
    end
    in_a_valid = 1'b0;
    n_tests++; if (rcv !== 3) begin n_fail++; $display("FAIL bp_received: got %0d want 3", rcv); end
    n_tests++; if (sent !== 3) begin n_fail++; $display("FAIL bp_sent: got %0d want 3", sent); end
    repeat (3) begin
      @(posedge clock); #1;
      n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate: got %b want 0", out_a_valid); end
    end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", idle); end
  endtask

  task automatic test_d_stream();
    bit exp_v;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      in_d_ready = 1'b1;
      out_d_valid = (c < 8);
      od_opcode = 3'd1; od_size = 3'd3;
      od_source = 3'(c);
      od_data = 64'hA5A5_0000_0000_0000 | 64'(c);
      if (c < 8) begin
        n_tests++; if (out_d_ready !== 1'b1) begin n_fail++; $display("FAIL d_ready c%0d: got %b want 1", c, out_d_ready); end
      end
      exp_v = (c >= 1 && c <= 8);
      n_tests++; if (in_d_valid !== exp_v) begin n_fail++; $display("FAIL d_valid c%0d: got %b want %b", c, in_d_valid, exp_v); end
      if (exp_v) begin
        n_tests++; if (id_source !== 3'(c - 1)) begin n_fail++; $display("FAIL d_source c%0d: got %0d want %0d", c, id_source, c - 1); end
        n_tests++; if (id_data !== (64'hA5A5_0000_0000_0000 | 64'(c - 1))) begin n_fail++; $display("FAIL d_data c%0d: got %h want %h", c, id_data, 64'hA5A5_0000_0000_0000 | 64'(c - 1)); end
        n_tests++; if ({id_opcode, id_size} !== {3'd1, 3'd3}) begin n_fail++; $display("FAIL d_opsize c%0d: got %h want %h", c, {id_opcode, id_size}, {3'd1, 3'd3}); end
      end
    end
    out_d_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_beat_t nb;
    @(posedge clock); #1;
    out_a_ready = 1'b0; in_d_ready = 1'b0;
    in_a = rand_beat(); in_a_valid = 1'b1;
    out_d_valid = 1'b1; od_source = 3'd6; od_data = {$urandom, $urandom};
    @(posedge clock); #1;
    in_a = rand_beat(); out_d_valid = 1'b0;
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    n_tests++; if (in_a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", in_a_ready); end
    n_tests++; if (in_d_valid !== 1'b1) begin n_fail++; $display("FAIL mid_d_held: got %b want 1", in_d_valid); end
    reset = 1'b1; #1;
    n_tests++; if (out_d_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_d_ready: got %b want 0", out_d_ready); end
    @(posedge clock); #1;
    reset = 1'b0; #1;
    n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_a_valid: got %b want 0", out_a_valid); end
    n_tests++; if (in_d_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_d_valid: got %b want 0", in_d_valid); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b want 1", idle); end
    n_tests++; if (in_a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_a_ready: got %b want 1", in_a_ready); end
    n_tests++; if (out_a_beat() !== a_beat_t'(0)) begin n_fail++; $display("FAIL mid_bits_clear: got %h want 0", out_a_beat()); end
    nb = rand_beat();
    @(posedge clock); #1;
    in_a = nb; in_a_valid = 1'b1; out_a_ready = 1'b1;
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    n_tests++; if (out_a_beat() !== nb || out_a_valid !== 1'b1) begin n_fail++; $display("FAIL mid_new_beat: got %b/%h want 1/%h", out_a_valid, out_a_beat(), nb); end
    @(posedge clock); #1;
    n_tests++; if (out_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", out_a_valid); end
  endtask

  task automatic test_random_depth3();
    a_beat_t q [$];
    a_beat_t cur;
    bit pending = 0;
    bit exp_ready, exp_valid;
    int rcv = 0;
    cur = '0;
    for (int cyc = 0; cyc < 30000 && rcv < 1000 && n_fail < 50; cyc++) begin
      @(posedge clock); #1;
      if (!pending && $urandom_range(0, 99) < 60) begin
        cur = rand_beat();
        pending = 1;
      end
      s3_in_a_valid = pending;
      s3_in_a = cur;
      s3_out_a_ready = ($urandom_range(0, 99) < 50);
      exp_ready = (q.size() != 3);
      exp_valid = (q.size() != 0);
      n_tests++; if (s3_in_a_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, s3_in_a_ready, exp_ready); end
      n_tests++; if (s3_out_a_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, s3_out_a_valid, exp_valid); end
      if (exp_valid) begin
        n_tests++; if (s3_out_a_beat() !== q[0]) begin n_fail++; $display("FAIL rnd_bits beat%0d: got %h want %h", rcv, s3_out_a_beat(), q[0]); end
      end
      if (exp_valid && s3_out_a_ready) begin
        void'(q.pop_front());
        rcv++;
      end
      if (pending && exp_ready) begin
        q.push_back(cur);
        pending = 0;
      end
    end
    s3_in_a_valid = 1'b0;
    s3_out_a_ready = 1'b1;
    n_tests++; if (rcv < 1000) begin n_fail++; $display("FAIL rnd_budget: got %0d beats want 1000", rcv); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      exp_valid = (q.size() != 0);
      n_tests++; if (s3_out_a_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_drain_valid: got %b want %b", s3_out_a_valid, exp_valid); end
      if (exp_valid) begin
        n_tests++; if (s3_out_a_beat() !== q[0]) begin n_fail++; $display("FAIL rnd_drain_bits: got %h want %h", s3_out_a_beat(), q[0]); end
        void'(q.pop_front());
      end
    end
    n_tests++; if (s3_idle !== 1'b1) begin n_fail++; $display("FAIL rnd_idle: got %b want 1", s3_idle); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_a();
    test_backpressure();
    test_d_stream();
    test_reset_mid();
    test_random_depth3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
